cache_refill_controller: RTL and testbench
==========================================

Name:
cache_refill_controller

Overview:
Sequences a cache line miss for the set-associative instruction/data cache. It obtains a victim way from the replacement policy and reads the victim's metadata. A dirty victim is written back word by word, then the new line is refilled from the memory bus and its tag is installed. On completion it pulses `taken` to the policy, here as `repl_taken`, so the victim pointer advances exactly once per refill.

Parameters:
WAY_COUNT, 2, ways per set (power of 2)
SET_COUNT, 64, sets (power of 2)
WORDS_PER_LINE, 4, 32-bit words per line (power of 2, ≥2)
ADDR_WIDTH, 32, byte address width; TAG_W = ADDR_WIDTH - log2(SET_COUNT) - log2(WORDS_PER_LINE) - 2

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
miss_valid  in  1  miss request
miss_addr  in  ADDR_WIDTH  byte address of missing access
miss_ready  out  1  request accepted this cycle (high only in IDLE)
done  out  1  one-cycle pulse: line installed
repl_way  in  log2(WAY_COUNT)  victim way from policy for arr_set
repl_ready  in  1  policy can supply a victim
repl_taken  out  1  one-cycle pulse: victim consumed
arr_set  out  log2(SET_COUNT)  set index to policy and arrays (latched from miss_addr)
arr_way  out  log2(WAY_COUNT)  latched victim way
arr_word  out  log2(WORDS_PER_LINE)  current word index
meta_rd  out  1  read victim metadata; meta_* valid next cycle
meta_valid  in  1  victim valid bit
meta_dirty  in  1  victim dirty bit
meta_tag  in  TAG_W  victim tag
data_rd  out  1  read victim word arr_word; data_rdata valid next cycle
data_rdata  in  32  victim word
data_we  out  1  write data_wdata to arr_set/arr_way/arr_word
data_wdata  out  32  refill word
tag_we  out  1  write tag_wdata with valid=1, dirty=0
tag_wdata  out  TAG_W  tag of miss_addr
mem_req  out  1  bus request, held until mem_gnt
mem_we  out  1  1 = write-back, 0 = refill read
mem_addr  out  ADDR_WIDTH  word-aligned bus address
mem_wdata  out  32  write-back data
mem_gnt  in  1  request accepted
mem_rvalid  in  1  response (read data or write ack), earliest cycle after mem_gnt
mem_rdata  in  32  read data

Behaviour:
- Reset: state IDLE, word counter 0. All outputs 0 except miss_ready=1. Latched address, way and tag registers are cleared.
- IDLE: miss_ready=1. When miss_valid is high, latch miss_addr and go to VICTIM.
- VICTIM: wait while repl_ready=0. When repl_ready=1, latch repl_way into arr_way, drive meta_rd=1 for one cycle, and go to META.
- META: sample meta_*. If meta_valid&meta_dirty, latch meta_tag and go to WB_RD with word=0. Otherwise go to FILL_REQ with word=0.
- WB_RD: drive data_rd=1 and go to WB_REQ. data_rdata is captured into the mem_wdata register on the next edge.
- WB_REQ: drive mem_req=1, mem_we=1, mem_addr={victim_tag, set, word, 2'b00}. Hold until mem_gnt, then go to WB_WAIT.
- WB_WAIT: wait for mem_rvalid. On the last word, go to FILL_REQ with word=0. Otherwise increment word and go to WB_RD.
- FILL_REQ: drive mem_req=1, mem_we=0, mem_addr={miss_tag, set, word, 2'b00}. Hold until mem_gnt, then go to FILL_WAIT.
- FILL_WAIT: on mem_rvalid, assert data_we=1 in the same cycle with data_wdata=mem_rdata (combinational). On the last word, go to COMMIT. Otherwise increment word and go to FILL_REQ.
- COMMIT: assert tag_we=1, repl_taken=1 and done=1 for one cycle, then go to IDLE.
- Word order is always 0 upward; there is no critical-word-first. The word counter wraps to 0 after the last word.
- mem_req, mem_addr, mem_we and mem_wdata are stable from request assertion until mem_gnt.
- mem_rvalid outside WB_WAIT/FILL_WAIT is ignored.
- arr_set and arr_way are constant from VICTIM through COMMIT, so the policy's taken updates the correct set.
- Latency with repl_ready=1 and zero-wait memory (gnt with req, rvalid next cycle), measured from the acceptance cycle c0:
  - clean victim: done at c0 + 3 + 2·WORDS_PER_LINE;
  - dirty victim: an additional 3·WORDS_PER_LINE cycles.
- miss_valid while busy: miss_ready=0 and nothing is latched.
- Reset mid-operation: immediate return to IDLE; no done or repl_taken; a partially written line is left as-is. The cache reset invalidates the arrays concurrently.

Test Plan:
1. Clean miss, defaults, miss_addr=0x0000_1234, repl_way=1, meta_valid=0, zero-wait memory returning 0xA0..0xA3 -> reads at 0x1230/1234/1238/123C; data_we words 0..3 set 35 way 1; tag_we tag 0x4; done and repl_taken single pulse at c11.
2. Same with meta_valid=meta_dirty=1, meta_tag=0x7, data_rdata 0xD0..0xD3 -> 4 writes to 0x1E30..0x1E3C with 0xD0..0xD3, all before the first read; done at c23.
3. mem_gnt held low 3 cycles on fill word 2 -> mem_req/mem_addr/mem_we stable throughout; done delayed by exactly 3 cycles.
4. repl_ready low 5 cycles; spurious mem_rvalid pulses in IDLE and VICTIM -> no meta_rd and no mem_req until repl_ready; rvalid ignored; miss_ready=0 after acceptance.
5. Second miss_valid held during refill -> not accepted until the cycle after done; then processed normally with word counter 0.
6. reset asserted during FILL_WAIT word 2 -> same cycle: miss_ready=1, all other outputs 0; no done/repl_taken; the next miss restarts at word 0.

Source files
------------

// File: rtl/cache_refill_controller.sv
// rtl/cache_refill_controller.sv - cache line miss sequencer: victim pick, dirty write-back, line refill, tag install
module cache_refill_controller #(
    parameter int WAY_COUNT      = 2,
    parameter int SET_COUNT      = 64,
    parameter int WORDS_PER_LINE = 4,
    parameter int ADDR_WIDTH     = 32,
    localparam int WAY_W  = (WAY_COUNT > 1) ? $clog2(WAY_COUNT) : 1,
    localparam int SET_W  = $clog2(SET_COUNT),
    localparam int WORD_W = $clog2(WORDS_PER_LINE),
    localparam int TAG_W  = ADDR_WIDTH - SET_W - WORD_W - 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  miss_valid,
    input  logic [ADDR_WIDTH-1:0] miss_addr,
    output logic                  miss_ready,
    output logic                  done,
    input  logic [WAY_W-1:0]      repl_way,
    input  logic                  repl_ready,
    output logic                  repl_taken,
    output logic [SET_W-1:0]      arr_set,
    output logic [WAY_W-1:0]      arr_way,
    output logic [WORD_W-1:0]     arr_word,
    output logic                  meta_rd,
    input  logic                  meta_valid,
    input  logic                  meta_dirty,
    input  logic [TAG_W-1:0]      meta_tag,
    output logic                  data_rd,
    input  logic [31:0]           data_rdata,
    output logic                  data_we,
    output logic [31:0]           data_wdata,
    output logic                  tag_we,
    output logic [TAG_W-1:0]      tag_wdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [31:0]           mem_rdata
);
    typedef enum logic [3:0] {
        IDLE, VICTIM, META, WB_RD, WB_REQ, WB_WAIT, FILL_REQ, FILL_WAIT, COMMIT
    } state_t;

    state_t              state_q, state_n;
    logic [TAG_W-1:0]    miss_tag_q, victim_tag_q;
    logic [SET_W-1:0]    set_q;
    logic [WAY_W-1:0]    way_q;
    logic [WORD_W-1:0]   word_q;
    logic [31:0]         wdata_q;
    logic                rd_pending_q;
    logic                last_word;
    logic                unused_offset;

    assign unused_offset = ^miss_addr[WORD_W+1:0];
    assign last_word     = (word_q == WORD_W'(WORDS_PER_LINE - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            miss_tag_q   <= '0;
            victim_tag_q <= '0;
            set_q        <= '0;
            way_q        <= '0;
            word_q       <= '0;
            wdata_q      <= '0;
            rd_pending_q <= 1'b0;
        end else begin
            state_q      <= state_n;
            rd_pending_q <= (state_q == WB_RD);
            if (rd_pending_q)
                wdata_q <= data_rdata;
            case (state_q)
                IDLE: if (miss_valid) begin
                    miss_tag_q <= miss_addr[ADDR_WIDTH-1 -: TAG_W];
                    set_q      <= miss_addr[WORD_W+2 +: SET_W];
                end
                VICTIM: if (repl_ready) way_q <= repl_way;
                META: begin
                    word_q <= '0;
                    if (meta_valid && meta_dirty)
                        victim_tag_q <= meta_tag;
                end
                WB_WAIT, FILL_WAIT: if (mem_rvalid) word_q <= last_word ? '0 : word_q + 1'b1;
                default: ;
            endcase
        end
    end

    // The metadata read happens in the cycle repl_way is taken, so the way is forwarded then.
    assign arr_way    = (state_q == VICTIM) ? repl_way : way_q;
    assign arr_set    = set_q;
    assign arr_word   = word_q;
    assign tag_wdata  = miss_tag_q;
    // Array read data arrives one cycle after data_rd; pass it straight through, then hold it.
    assign mem_wdata  = rd_pending_q ? data_rdata : wdata_q;
    assign data_wdata = data_we ? mem_rdata : '0;

    always_comb begin
        state_n    = state_q;
        miss_ready = 1'b0;
        done       = 1'b0;
        repl_taken = 1'b0;
        meta_rd    = 1'b0;
        data_rd    = 1'b0;
        data_we    = 1'b0;
        tag_we     = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        case (state_q)
            IDLE: begin
                miss_ready = 1'b1;
                if (miss_valid) state_n = VICTIM;
            end
            VICTIM: if (repl_ready) begin
                meta_rd = 1'b1;
                state_n = META;
            end
            META: state_n = (meta_valid && meta_dirty) ? WB_RD : FILL_REQ;
            WB_RD: begin
                data_rd = 1'b1;
                state_n = WB_REQ;
            end
            WB_REQ: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                mem_addr = {victim_tag_q, set_q, word_q, 2'b00};
                if (mem_gnt) state_n = WB_WAIT;
            end
            WB_WAIT: if (mem_rvalid) state_n = last_word ? FILL_REQ : WB_RD;
            FILL_REQ: begin
                mem_req  = 1'b1;
                mem_addr = {miss_tag_q, set_q, word_q, 2'b00};
                if (mem_gnt) state_n = FILL_WAIT;
            end
            FILL_WAIT: if (mem_rvalid) begin
                data_we = 1'b1;
                state_n = last_word ? COMMIT : FILL_REQ;
            end
            COMMIT: begin
                tag_we     = 1'b1;
                repl_taken = 1'b1;
                done       = 1'b1;
                state_n    = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_cache_refill_controller.sv
// tb/tb_cache_refill_controller.sv - randomized self-checking bench for cache_refill_controller
module tb_cache_refill_controller;
    localparam int WPL   = 4;
    localparam int TAG_W = 22;

    logic clk = 1'b0;
    logic reset, miss_valid, miss_ready, done, repl_ready, repl_taken;
    logic [31:0] miss_addr;
    logic [0:0] repl_way, arr_way;
    logic [5:0] arr_set;
    logic [1:0] arr_word;
    logic meta_rd, meta_valid, meta_dirty, data_rd, data_we, tag_we;
    logic [TAG_W-1:0] meta_tag, tag_wdata;
    logic [31:0] data_rdata, data_wdata, mem_addr, mem_wdata, mem_rdata;
    logic mem_req, mem_we, mem_gnt, mem_rvalid;

    always #5 clk = ~clk;

    cache_refill_controller #(.WAY_COUNT(2), .SET_COUNT(64), .WORDS_PER_LINE(WPL), .ADDR_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .miss_valid(miss_valid), .miss_addr(miss_addr),
        .miss_ready(miss_ready), .done(done), .repl_way(repl_way), .repl_ready(repl_ready),
        .repl_taken(repl_taken), .arr_set(arr_set), .arr_way(arr_way), .arr_word(arr_word),
        .meta_rd(meta_rd), .meta_valid(meta_valid), .meta_dirty(meta_dirty), .meta_tag(meta_tag),
        .data_rd(data_rd), .data_rdata(data_rdata), .data_we(data_we), .data_wdata(data_wdata),
        .tag_we(tag_we), .tag_wdata(tag_wdata), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Environment configuration and observation logs
    logic [31:0] fill_data [4];
    logic [31:0] vic_data [4];
    logic [0:0]  cfg_way;
    bit          cfg_valid, cfg_dirty, spur_en;
    logic [TAG_W-1:0] cfg_tag;
    int repl_low, gnt_stall, cyc, first_req_cyc, stab_viol;
    bit rsp_pending, meta_pending, rd_pend, prev_wait;
    logic [1:0]  rd_word;
    logic [31:0] rsp_data;
    logic [64:0] prev_req;
    logic [64:0] bus_q[$], exp_bus[$];
    logic [40:0] wr_q[$], exp_wr[$];
    logic [28:0] tag_q[$], exp_tag[$];
    logic [6:0]  meta_loc_q[$], exp_meta[$];
    int done_q[$], taken_q[$], meta_q[$], accept_q[$];
    bit rdy_hist[int];

    // Memory, array and policy responder plus per-cycle monitor
    initial begin
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0; data_rdata = 0; repl_ready = 0; repl_way = 0;
        meta_valid = 0; meta_dirty = 0; meta_tag = 0;
        rsp_pending = 0; meta_pending = 0; rd_pend = 0; prev_wait = 0; rd_word = 0; rsp_data = 0;
        prev_req = 0; cyc = 0;
        forever begin
            @(negedge clk);
            mem_rvalid = rsp_pending ? 1'b1 : (spur_en ? 1'($urandom) : 1'b0);
            mem_rdata  = rsp_pending ? rsp_data : $urandom;
            data_rdata = rd_pend ? vic_data[rd_word] : $urandom;
            meta_valid = meta_pending ? cfg_valid : 1'($urandom);
            meta_dirty = meta_pending ? cfg_dirty : 1'($urandom);
            meta_tag   = meta_pending ? cfg_tag : TAG_W'($urandom);
            if (!miss_ready && repl_low > 0) begin
                repl_ready = 0;
                repl_low--;
            end else
                repl_ready = 1;
            repl_way = repl_ready ? cfg_way : 1'($urandom);
            if (mem_req && !mem_we && mem_addr[3:2] == 2'd2 && gnt_stall > 0) begin
                mem_gnt = 0;
                gnt_stall--;
            end else
                mem_gnt = mem_req;
            #1;
            rdy_hist[cyc] = miss_ready;
            if (prev_wait && (!mem_req || {mem_we, mem_addr, mem_wdata} !== prev_req)) stab_viol++;
            prev_wait = mem_req && !mem_gnt;
            prev_req  = {mem_we, mem_addr, mem_wdata};
            rsp_pending = mem_req && mem_gnt;
            if (rsp_pending) begin
                bus_q.push_back({mem_we, mem_addr, mem_we ? mem_wdata : 32'h0});
                rsp_data = fill_data[mem_addr[3:2]];
                if (first_req_cyc < 0) first_req_cyc = cyc;
            end
            if (data_we) wr_q.push_back({arr_set, arr_way, arr_word, data_wdata});
            if (tag_we) tag_q.push_back({arr_set, arr_way, tag_wdata});
            if (done) done_q.push_back(cyc);
            if (repl_taken) taken_q.push_back(cyc);
            if (meta_rd) begin
                meta_q.push_back(cyc);
                meta_loc_q.push_back({arr_set, arr_way});
            end
            if (miss_valid && miss_ready) accept_q.push_back(cyc);
            meta_pending = meta_rd;
            rd_pend = data_rd;
            rd_word = arr_word;
            cyc++;
        end
    end

    task automatic clear_logs();
        bus_q.delete(); wr_q.delete(); tag_q.delete(); meta_loc_q.delete();
        exp_bus.delete(); exp_wr.delete(); exp_tag.delete(); exp_meta.delete();
        done_q.delete(); taken_q.delete(); meta_q.delete(); accept_q.delete(); rdy_hist.delete();
        first_req_cyc = -1; stab_viol = 0;
    endtask

    // Reference: whole-line transaction list derived from the address split and victim state
    task automatic model_miss(input logic [31:0] a, input logic [0:0] way, input bit wb, input logic [TAG_W-1:0] vtag);
        int set;
        logic [31:0] mtag, vt, ba;
        set  = (a / 16) % 64;
        mtag = a / 1024;
        vt   = 32'(vtag);
        exp_meta.push_back({6'(set), way});
        if (wb)
            for (int w = 0; w < WPL; w++) begin
                ba = vt * 1024 + 32'(set) * 16 + 32'(w) * 4;
                exp_bus.push_back({1'b1, ba, vic_data[w]});
            end
        for (int w = 0; w < WPL; w++) begin
            ba = mtag * 1024 + 32'(set) * 16 + 32'(w) * 4;
            exp_bus.push_back({1'b0, ba, 32'h0});
            exp_wr.push_back({6'(set), way, 2'(w), fill_data[w]});
        end
        exp_tag.push_back({6'(set), way, TAG_W'(mtag)});
    endtask

    task automatic issue_miss(input logic [31:0] a, input bit hold, output bit ok);
        int n;
        n = accept_q.size();
        ok = 0;
        @(negedge clk);
        miss_addr = a;
        miss_valid = 1;
        for (int i = 0; i < 100; i++) begin
            #2;
            if (accept_q.size() > n) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (!hold) begin
            @(negedge clk);
            miss_valid = 0;
        end
    endtask

    task automatic wait_done(input int n, output bit ok);
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            #2;
            if (done_q.size() >= n) begin
                ok = 1;
                break;
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        #2;
        n_cmp++;
        if (miss_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b expected 1", miss_ready); end
        n_cmp++;
        if ({done, repl_taken, arr_set, arr_way, arr_word, meta_rd, data_rd, data_we, data_wdata, tag_we,
             tag_wdata, mem_req, mem_we, mem_addr, mem_wdata} !== '0) begin
            n_err++; $display("FAIL reset_outputs: got nonzero outputs expected all 0");
        end
        @(negedge clk);
        reset = 0;
        #2;
        n_cmp++;
        if (miss_ready !== 1'b1 || mem_req !== 1'b0) begin
            n_err++; $display("FAIL post_reset_idle: got ready=%b req=%b expected 1/0", miss_ready, mem_req);
        end
    endtask

    task automatic test_refill(input string name, input logic [31:0] a, input logic [0:0] way, input bit v,
                               input bit d, input logic [TAG_W-1:0] vtag, input int rlow, input int stall,
                               input bit spur);
        bit ok;
        int acc, exp_done, busy_rdy;
        clear_logs();
        cfg_way = way; cfg_valid = v; cfg_dirty = d; cfg_tag = vtag;
        repl_low = rlow; gnt_stall = stall; spur_en = spur;
        model_miss(a, way, v && d, vtag);
        issue_miss(a, 0, ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL %s accept: got timeout expected acceptance", name); end
        wait_done(1, ok);
        spur_en = 0;
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL %s done_wait: got timeout expected done", name); return; end
        acc = accept_q[0];
        exp_done = acc + 3 + 2 * WPL + ((v && d) ? 3 * WPL : 0) + rlow + stall;
        n_cmp++;
        if (done_q.size() != 1 || done_q[0] != exp_done) begin
            n_err++; $display("FAIL %s done_cycle: got %0d (count %0d) expected %0d", name, done_q[0] - acc, done_q.size(), exp_done - acc);
        end
        n_cmp++;
        if (taken_q.size() != 1 || taken_q[0] != done_q[0]) begin
            n_err++; $display("FAIL %s repl_taken: got count %0d expected one pulse with done", name, taken_q.size());
        end
        n_cmp++;
        if (meta_loc_q.size() != 1 || meta_loc_q[0] !== exp_meta[0]) begin
            n_err++; $display("FAIL %s meta_rd: got count %0d expected single read at set/way %h", name, meta_loc_q.size(), exp_meta[0]);
        end
        for (int i = 0; i < exp_bus.size(); i++) begin
            n_cmp++;
            if (i >= bus_q.size() || bus_q[i] !== exp_bus[i]) begin
                n_err++; $display("FAIL %s bus[%0d]: got %h expected %h", name, i, (i < bus_q.size()) ? bus_q[i] : 65'h0, exp_bus[i]);
            end
        end
        for (int i = 0; i < exp_wr.size(); i++) begin
            n_cmp++;
            if (i >= wr_q.size() || wr_q[i] !== exp_wr[i]) begin
                n_err++; $display("FAIL %s data_we[%0d]: got %h expected %h", name, i, (i < wr_q.size()) ? wr_q[i] : 41'h0, exp_wr[i]);
            end
        end
        n_cmp++;
        if (bus_q.size() != exp_bus.size() || wr_q.size() != exp_wr.size()) begin
            n_err++; $display("FAIL %s counts: got bus %0d wr %0d expected %0d %0d", name, bus_q.size(), wr_q.size(), exp_bus.size(), exp_wr.size());
        end
        n_cmp++;
        if (tag_q.size() != 1 || tag_q[0] !== exp_tag[0]) begin
            n_err++; $display("FAIL %s tag_we: got %h (count %0d) expected %h", name, tag_q[0], tag_q.size(), exp_tag[0]);
        end
        n_cmp++;
        if (stab_viol != 0) begin n_err++; $display("FAIL %s req_stable: got %0d changes expected 0", name, stab_viol); end
        busy_rdy = 0;
        for (int c = acc + 1; c <= done_q[0]; c++) if (rdy_hist[c]) busy_rdy++;
        n_cmp++;
        if (busy_rdy != 0) begin n_err++; $display("FAIL %s busy_ready: got %0d ready cycles expected 0", name, busy_rdy); end
    endtask

    task automatic test_clean_miss();
        cfg_valid = 0;
        for (int w = 0; w < WPL; w++) fill_data[w] = 32'hA0 + 32'(w);
        test_refill("clean", 32'h0000_1234, 1'b1, 1'b0, 1'b0, 22'h0, 0, 0, 1'b0);
    endtask

    task automatic test_dirty_miss();
        for (int w = 0; w < WPL; w++) begin
            fill_data[w] = 32'hA0 + 32'(w);
            vic_data[w]  = 32'hD0 + 32'(w);
        end
        test_refill("dirty", 32'h0000_1234, 1'b1, 1'b1, 1'b1, 22'h7, 0, 0, 1'b0);
    endtask

    task automatic test_gnt_stall();
        test_refill("gnt_stall", 32'h0000_1234, 1'b0, 1'b0, 1'b1, 22'h3, 0, 3, 1'b0);
        n_cmp++;
        if (gnt_stall != 0) begin n_err++; $display("FAIL gnt_stall consumed: got %0d left expected 0", gnt_stall); end
    endtask

    task automatic test_victim_wait();
        test_refill("victim_wait", 32'h0004_5678, 1'b1, 1'b0, 1'b0, 22'h0, 5, 0, 1'b1);
        n_cmp++;
        if (meta_q.size() != 1 || accept_q.size() != 1 || meta_q[0] != accept_q[0] + 6) begin
            n_err++; $display("FAIL victim_wait meta_cycle: got %0d expected %0d", meta_q[0], accept_q[0] + 6);
        end
        n_cmp++;
        if (first_req_cyc <= meta_q[0]) begin
            n_err++; $display("FAIL victim_wait early_req: got req at %0d expected after %0d", first_req_cyc, meta_q[0]);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        clear_logs();
        cfg_way = 0; cfg_valid = 0; cfg_dirty = 0; repl_low = 0; gnt_stall = 0;
        for (int w = 0; w < WPL; w++) fill_data[w] = $urandom;
        model_miss(32'h0000_2040, 1'b0, 0, '0);
        model_miss(32'h0003_3F0C, 1'b0, 0, '0);
        issue_miss(32'h0000_2040, 1, ok);
        @(negedge clk);
        miss_addr = 32'h0003_3F0C;
        for (int i = 0; i < 100 && accept_q.size() < 2; i++) begin
            @(negedge clk);
            #2;
        end
        @(negedge clk);
        miss_valid = 0;
        wait_done(2, ok);
        n_cmp++;
        if (!ok || accept_q.size() != 2) begin
            n_err++; $display("FAIL b2b progress: got %0d accepts %0d dones expected 2 2", accept_q.size(), done_q.size());
            return;
        end
        n_cmp++;
        if (accept_q[1] != done_q[0] + 1) begin
            n_err++; $display("FAIL b2b accept_cycle: got %0d expected %0d", accept_q[1], done_q[0] + 1);
        end
        n_cmp++;
        if (done_q[1] != accept_q[1] + 3 + 2 * WPL) begin
            n_err++; $display("FAIL b2b second_done: got %0d expected %0d", done_q[1] - accept_q[1], 3 + 2 * WPL);
        end
        for (int i = 0; i < exp_bus.size(); i++) begin
            n_cmp++;
            if (i >= bus_q.size() || bus_q[i] !== exp_bus[i]) begin
                n_err++; $display("FAIL b2b bus[%0d]: got %h expected %h", i, (i < bus_q.size()) ? bus_q[i] : 65'h0, exp_bus[i]);
            end
        end
        for (int i = 0; i < exp_tag.size(); i++) begin
            n_cmp++;
            if (i >= tag_q.size() || tag_q[i] !== exp_tag[i]) begin
                n_err++; $display("FAIL b2b tag[%0d]: got %h expected %h", i, (i < tag_q.size()) ? tag_q[i] : 29'h0, exp_tag[i]);
            end
        end
    endtask

    task automatic test_reset_mid_fill();
        bit ok;
        clear_logs();
        cfg_way = 1; cfg_valid = 0; cfg_dirty = 0; repl_low = 0; gnt_stall = 0;
        for (int w = 0; w < WPL; w++) fill_data[w] = $urandom;
        issue_miss(32'h0000_0AB0, 0, ok);
        for (int i = 0; i < 100 && bus_q.size() < 3; i++) begin
            @(negedge clk);
            #2;
        end
        @(negedge clk);
        reset = 1;
        #2;
        n_cmp++;
        if (miss_ready !== 1'b1 || {done, repl_taken, arr_set, arr_way, arr_word, meta_rd, data_rd, data_we,
             data_wdata, tag_we, tag_wdata, mem_req, mem_we, mem_addr, mem_wdata} !== '0) begin
            n_err++; $display("FAIL reset_mid outputs: got ready=%b req=%b we=%b expected idle", miss_ready, mem_req, data_we);
        end
        repeat (2) @(negedge clk);
        reset = 0;
        repeat (3) @(negedge clk);
        #2;
        n_cmp++;
        if (done_q.size() != 0 || taken_q.size() != 0 || wr_q.size() != 2) begin
            n_err++; $display("FAIL reset_mid pulses: got done %0d taken %0d writes %0d expected 0 0 2", done_q.size(), taken_q.size(), wr_q.size());
        end
        for (int w = 0; w < WPL; w++) fill_data[w] = $urandom;
        test_refill("after_reset", 32'h0000_0AB8, 1'b0, 1'b0, 1'b0, 22'h0, 0, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 6; k++) begin
            for (int w = 0; w < WPL; w++) begin
                fill_data[w] = $urandom;
                vic_data[w]  = $urandom;
            end
            test_refill($sformatf("random%0d", k), $urandom, 1'($urandom), 1'($urandom), 1'($urandom),
                        TAG_W'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
        end
    endtask

    initial begin
        reset = 1; miss_valid = 0; miss_addr = 0;
        spur_en = 0; repl_low = 0; gnt_stall = 0; cfg_way = 0; cfg_valid = 0; cfg_dirty = 0; cfg_tag = 0;
        first_req_cyc = -1; stab_viol = 0;
        for (int w = 0; w < WPL; w++) begin
            fill_data[w] = 0;
            vic_data[w]  = 0;
        end
        test_reset();
        test_clean_miss();
        test_dirty_miss();
        test_gnt_stall();
        test_victim_wait();
        test_back_to_back();
        test_reset_mid_fill();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
